// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a first-word-fall-through FIFO.
// i_rx is synchronised into clk, framed by a two-process FSM, and each good byte
// is pushed into a DEPTH-entry FIFO. Framing and overrun errors are sticky until
// i_clr_err.
// Optional build macro UART_RX_PARITY_EN: adds an even-parity bit between the
// data bits and the stop bit, plus the sticky output o_parity_err.
module uart_rx_fifo #(
    parameter int CLK_HZ = 13300000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_rx,
    input  logic          i_rd,
    input  logic          i_clr_err,
    output logic [7:0]    o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count,
    output logic          o_frame_err,
    output logic          o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic          o_parity_err,
`endif
    output logic          o_busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = ST_PARITY;
`else
    localparam state_t AFTER_DATA = ST_STOP;
`endif

    // Receiver state
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_bad_q, par_bad_d;
    logic            sync1_q, rx_s_q;
    logic            rx_s;
    logic            push_s, ferr_set_s;

    // FIFO state
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            empty_q, empty_d, full_q, full_d, busy_q, busy_d;
    logic            do_push_s, do_pop_s, ovr_set_s;

    // Sticky status
    logic            ferr_q, ferr_d, ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d, perr_set_s;
`endif

    assign rx_s = rx_s_q;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            rx_s_q  <= sync1_q;
        end
    end

    // Receiver next-state: start detect, mid-bit sampling, stop/parity checks.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (!rx_s) begin
                    state_d   = ST_START;
                    par_bad_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    bit_d   = 3'd0;
                    // A line that is high again at mid start bit was a glitch.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = {CW{1'b0}};
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_STOP;
                    // Even parity: XOR of data plus parity bit must be zero.
                    if (^{rx_s, shift_q}) begin
                        par_bad_d  = 1'b1;
                        perr_set_s = 1'b1;
                    end else begin
                        par_bad_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == LAST) begin
                    // Leave at mid stop bit so the next start edge has half a bit of slack.
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        push_s = !par_bad_q;
                    end else begin
                        ferr_set_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // FIFO bookkeeping: push/pop arbitration, pointers, count and flags.
    always_comb begin
        do_pop_s  = i_rd && (count_q != {CNTW{1'b0}});
        do_push_s = push_s && ((count_q != FULL_CNT) || do_pop_s);
        ovr_set_s = push_s && (count_q == FULL_CNT) && !do_pop_s;
        wr_ptr_d  = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d   = count_q + CNTW'(do_push_s) - CNTW'(do_pop_s);
        empty_d   = (count_d == {CNTW{1'b0}});
        full_d    = (count_d == FULL_CNT);
        busy_d    = (state_d != ST_IDLE);
    end

    // Sticky error flags: a new error in the same cycle as a clear wins.
    always_comb begin
        if (ferr_set_s) begin
            ferr_d = 1'b1;
        end else if (i_clr_err) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (i_clr_err) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
`ifdef UART_RX_PARITY_EN
        if (perr_set_s) begin
            perr_d = 1'b1;
        end else if (i_clr_err) begin
            perr_d = 1'b0;
        end else begin
            perr_d = perr_q;
        end
`endif
    end

    // Register bank for receiver, FIFO control and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            par_bad_q <= 1'b0;
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {CNTW{1'b0}};
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // FIFO storage; cleared on reset so the head reads zero when nothing is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign o_data      = mem_q[rd_ptr_q];
    assign o_empty     = empty_q;
    assign o_full      = full_q;
    assign o_count     = count_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 16 clocks per bit.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset, i_rx, i_rd, i_clr_err;
    logic [7:0]    o_data;
    logic          o_empty, o_full, o_frame_err, o_overrun, o_busy;
    logic [AW:0]   o_count;
`ifdef UART_RX_PARITY_EN
    logic          o_parity_err;
`endif

    uart_rx_fifo #(.CLK_HZ(1600), .BAUD(100), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .i_rx(i_rx), .i_rd(i_rd), .i_clr_err(i_clr_err),
        .o_data(o_data), .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
        .o_frame_err(o_frame_err), .o_overrun(o_overrun),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_busy(o_busy));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Edge monitor: cycle numbers at which busy and empty last fell.
    int cyc = 0, busy_fall = -1, empty_fall = -1;
    logic prev_busy = 1'b0, prev_empty = 1'b1;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_busy && !o_busy) busy_fall = cyc;
        if (prev_empty && !o_empty) empty_fall = cyc;
        prev_busy  = o_busy;
        prev_empty = o_empty;
    end

    // Reference model: a queue of held bytes and the two sticky flags.
    logic [7:0] mq[$];
    logic m_ovr, m_ferr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pop_after;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; i_rd is pulsed at negedge number rd_at counted from the start bit.
    task automatic send_bits(input logic [7:0] d, input logic par, input logic stop, input int rd_at);
        logic [10:0] bits;
        int nb, k;
`ifdef UART_RX_PARITY_EN
        bits = {stop, par, d, 1'b0};
        nb = 11;
`else
        bits = {par, stop, d, 1'b0};
        nb = 10;
`endif
        k = 0;
        for (int b = 0; b < nb; b++) begin
            i_rx = bits[b];
            for (int t = 0; t < CPB; t++) begin
                i_rd = (k == rd_at);
                tick(1);
                k++;
            end
        end
        i_rx = 1'b1;
        i_rd = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 64) begin
            tick(1);
            n++;
        end
        if (o_busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, ^d, stop, -1);
        tick(24);
        wait_idle();
    endtask

    task automatic pop();
        i_rd = 1'b1;
        tick(1);
        i_rd = 1'b0;
    endtask

    task automatic clr_err();
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_rx = 1'b1; i_rd = 1'b0; i_clr_err = 1'b0;
        tick(2);
        check("rst_data", o_data, 8'h00);
        check("rst_empty", o_empty, 1'b1);
        check("rst_full", o_full, 1'b0);
        check("rst_count", o_count, 5'd0);
        check("rst_ferr", o_frame_err, 1'b0);
        check("rst_ovr", o_overrun, 1'b0);
        check("rst_busy", o_busy, 1'b0);
`ifdef UART_RX_PARITY_EN
        check("rst_perr", o_parity_err, 1'b0);
`endif
        reset = 1'b0;
        tick(2);
        mq.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, o_count, mq.size());
        check({tag, "_empty"}, o_empty, mq.size() == 0);
        check({tag, "_full"}, o_full, mq.size() == DEPTH);
        if (mq.size() > 0) check({tag, "_head"}, o_data, mq[0]);
        check({tag, "_ovr"}, o_overrun, m_ovr);
        check({tag, "_ferr"}, o_frame_err, m_ferr);
    endtask

    initial begin
        reset = 1'b1; i_rx = 1'b1; i_rd = 1'b0; i_clr_err = 1'b0;
        tick(3);
        do_reset();

        // Single byte: head valid on the same edge the receiver goes idle.
        send_frame(8'hA5, 1'b1);
        check("lat_empty_fall", empty_fall, busy_fall);
        check("lat_data", o_data, 8'hA5);
        check("lat_count", o_count, 5'd1);
        pop();
        check("lat_pop_empty", o_empty, 1'b1);
        check("lat_pop_count", o_count, 5'd0);
        pop();
        check("pop_empty_ignored", o_count, 5'd0);

        // Fill to 16, then overflow with a 17th byte.
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
        check("fill_full", o_full, 1'b1);
        check("fill_count", o_count, 5'd16);
        check("fill_ovr", o_overrun, 1'b1);
        check("fill_head", o_data, 8'h01);
        for (int i = 1; i <= 16; i++) begin
            check("drain_data", o_data, 8'(i));
            pop();
        end
        check("drain_empty", o_empty, 1'b1);
        clr_err();
        check("clr_ovr", o_overrun, 1'b0);

        // Glitch on an idle line must abort in START.
        i_rx = 1'b0;
        tick(4);
        check("glitch_busy", o_busy, 1'b1);
        i_rx = 1'b1;
        tick(20);
        check("glitch_idle", o_busy, 1'b0);
        check("glitch_count", o_count, 5'd0);
        check("glitch_ferr", o_frame_err, 1'b0);

        // Table-driven frames, including a framing error.
        vecs[0] = '{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1'b1};
        vecs[1] = '{8'h55, 1'b1, 1'b0, 1, 8'h55, 1'b1};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 2, 8'h55, 1'b1};
        vecs[3] = '{8'h7E, 1'b1, 1'b1, 2, 8'hA5, 1'b1};
        vecs[4] = '{8'hC3, 1'b1, 1'b1, 2, 8'h7E, 1'b1};
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            if (vecs[v].pop_after) pop();
            check("vec_count", o_count, vecs[v].exp_count);
            if (vecs[v].exp_count > 0) check("vec_head", o_data, vecs[v].exp_head);
            check("vec_ferr", o_frame_err, vecs[v].exp_ferr);
            check("vec_busy", o_busy, 1'b0);
        end

        // Full FIFO with a pop in the exact push cycle of the 17th byte.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h20 + 8'(i), 1'b1);
            mq.push_back(8'h20 + 8'(i));
        end
        send_bits(8'h99, ^8'h99, 1'b1, CPB * (($bits(o_data) + 2) - 1
`ifdef UART_RX_PARITY_EN
            + 1
`endif
            ) + 10);
        tick(24);
        wait_idle();
        void'(mq.pop_front());
        mq.push_back(8'h99);
        check_model("simul");
        while (mq.size() > 0) begin
            check("simul_drain", o_data, mq.pop_front());
            pop();
        end
        check("simul_empty", o_empty, 1'b1);

        // Reset in the middle of DATA, then a clean byte.
        send_frame(8'h11, 1'b1);
        i_rx = 1'b0;
        tick(CPB * 3);
        i_rx = 1'b1;
        do_reset();
        tick(20);
        send_frame(8'h7E, 1'b1);
        check("post_rst_data", o_data, 8'h7E);
        check("post_rst_count", o_count, 5'd1);

`ifdef UART_RX_PARITY_EN
        do_reset();
        send_bits(8'h03, 1'b1, 1'b1, -1);
        tick(24);
        wait_idle();
        check("par_bad_err", o_parity_err, 1'b1);
        check("par_bad_count", o_count, 5'd0);
        send_bits(8'h03, 1'b0, 1'b1, -1);
        tick(24);
        wait_idle();
        check("par_ok_count", o_count, 5'd1);
        check("par_ok_data", o_data, 8'h03);
        clr_err();
        check("par_clr", o_parity_err, 1'b0);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int op = 0; op < 45; op++) begin
            int r;
            logic [7:0] d;
            logic good;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                d = 8'($urandom);
                good = ($urandom_range(0, 7) != 0);
                send_frame(d, good);
                if (!good) m_ferr = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(d);
                else m_ovr = 1'b1;
            end else if (r < 93) begin
                pop();
                if (mq.size() > 0) void'(mq.pop_front());
            end else begin
                clr_err();
                m_ovr = 1'b0;
                m_ferr = 1'b0;
            end
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
